// File: rtl/emulib_rammodel_tracker_ex.sv
// AXI4 transaction tracker for the RAM model frontend.
// Gates AW/W/AR acceptance from registered in-flight counters, keeps per-burst
// length FIFOs to check W and R burst lengths, and raises sticky trigger flags
// on protocol violations observed on the B and R channels.
module emulib_rammodel_tracker_ex #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int ID_WIDTH       = 4,
    parameter int MAX_R_INFLIGHT = 8,
    parameter int MAX_W_INFLIGHT = 8,
    parameter int RW_MODE        = 0,
    localparam int RCW = $clog2(MAX_R_INFLIGHT + 1),
    localparam int WCW = $clog2(MAX_W_INFLIGHT + 1)
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           axi_awvalid,
    output logic           axi_awready,
    input  logic [7:0]     axi_awlen,

    input  logic           axi_wvalid,
    output logic           axi_wready,
    input  logic           axi_wlast,

    input  logic           axi_arvalid,
    output logic           axi_arready,
    input  logic [7:0]     axi_arlen,

    input  logic           axi_bvalid,
    input  logic           axi_bready,

    input  logic           axi_rvalid,
    input  logic           axi_rready,
    input  logic           axi_rlast,

    output logic [RCW-1:0] r_inflight,
    output logic [WCW-1:0] w_inflight,

    (* remu_trigger *) output logic err_w_len,
    (* remu_trigger *) output logic err_r_len,
    (* remu_trigger *) output logic err_b_unexp,
    (* remu_trigger *) output logic err_r_unexp
);

    // FIFO pointer widths; a depth-1 FIFO still needs a 1-bit pointer.
    localparam int RPW = (MAX_R_INFLIGHT > 1) ? $clog2(MAX_R_INFLIGHT) : 1;
    localparam int WPW = (MAX_W_INFLIGHT > 1) ? $clog2(MAX_W_INFLIGHT) : 1;

    localparam logic [RCW-1:0] R_MAX  = RCW'(MAX_R_INFLIGHT);
    localparam logic [WCW-1:0] W_MAX  = WCW'(MAX_W_INFLIGHT);
    localparam logic [RPW-1:0] R_LAST = RPW'(MAX_R_INFLIGHT - 1);
    localparam logic [WPW-1:0] W_LAST = WPW'(MAX_W_INFLIGHT - 1);

    if (ADDR_WIDTH < 1 || DATA_WIDTH < 8 || ID_WIDTH < 1 ||
        MAX_R_INFLIGHT < 1 || MAX_W_INFLIGHT < 1 ||
        (RW_MODE != 0 && RW_MODE != 1)) begin : g_param_check
        $error("emulib_rammodel_tracker_ex: illegal parameter combination");
    end

    // Outstanding-transaction counters.
    // wpend doubles as the awlen FIFO occupancy, r_cnt as the arlen FIFO occupancy.
    logic [RCW-1:0] r_cnt;
    logic [WCW-1:0] w_cnt;
    logic [WCW-1:0] wpend;
    logic [WCW-1:0] wdone;

    // Burst length FIFOs.
    logic [7:0]     aw_mem [MAX_W_INFLIGHT];
    logic [WPW-1:0] aw_rd;
    logic [WPW-1:0] aw_wr;
    logic [7:0]     ar_mem [MAX_R_INFLIGHT];
    logic [RPW-1:0] ar_rd;
    logic [RPW-1:0] ar_wr;
    logic [7:0]     aw_head;
    logic [7:0]     ar_head;

    // Beat counters within the current W / R burst.
    logic [8:0]     wcnt;
    logic [8:0]     rcnt;
    logic [8:0]     wcnt_inc;
    logic [8:0]     rcnt_inc;

    // Handshake qualifiers.
    logic aw_fire;
    logic w_fire;
    logic w_last_fire;
    logic ar_fire;
    logic r_fire;
    logic r_ok;
    logic r_last_fire;
    logic b_fire;
    logic b_ok;

    // Readies depend only on registered counters, never on the valids.
    always_comb begin
        axi_awready = (w_cnt != W_MAX);
        axi_wready  = (wpend != '0);
        if (RW_MODE == 0) begin
            axi_arready = (r_cnt != R_MAX) && (w_cnt == '0);
        end else begin
            axi_arready = (r_cnt != R_MAX) && (wpend == '0);
        end
    end

    // Fire decoding and FIFO head selection.
    always_comb begin
        aw_fire     = axi_awvalid && axi_awready;
        w_fire      = axi_wvalid  && axi_wready;
        w_last_fire = w_fire && axi_wlast;
        ar_fire     = axi_arvalid && axi_arready;
        r_fire      = axi_rvalid  && axi_rready;
        // R beats with no outstanding read are flagged but otherwise ignored.
        r_ok        = r_fire && (r_cnt != '0);
        r_last_fire = r_ok && axi_rlast;
        b_fire      = axi_bvalid && axi_bready;
        // An unexpected B leaves w_cnt untouched so that w_cnt always equals
        // wpend + wdone and the awlen FIFO can never be overrun.
        b_ok        = b_fire && (wdone != '0);
        aw_head     = aw_mem[aw_rd];
        ar_head     = ar_mem[ar_rd];
        wcnt_inc    = wcnt + 9'd1;
        rcnt_inc    = rcnt + 9'd1;
    end

    // In-flight counters; simultaneous increment and decrement cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            w_cnt <= '0;
            wpend <= '0;
            wdone <= '0;
        end else begin
            case ({ar_fire, r_last_fire})
                2'b10:   r_cnt <= r_cnt + RCW'(1);
                2'b01:   r_cnt <= r_cnt - RCW'(1);
                default: r_cnt <= r_cnt;
            endcase
            case ({aw_fire, b_ok})
                2'b10:   w_cnt <= w_cnt + WCW'(1);
                2'b01:   w_cnt <= w_cnt - WCW'(1);
                default: w_cnt <= w_cnt;
            endcase
            case ({aw_fire, w_last_fire})
                2'b10:   wpend <= wpend + WCW'(1);
                2'b01:   wpend <= wpend - WCW'(1);
                default: wpend <= wpend;
            endcase
            case ({w_last_fire, b_ok})
                2'b10:   wdone <= wdone + WCW'(1);
                2'b01:   wdone <= wdone - WCW'(1);
                default: wdone <= wdone;
            endcase
        end
    end

    // FIFO pointers: push on address fire, pop on the matching last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_wr <= '0;
            aw_rd <= '0;
            ar_wr <= '0;
            ar_rd <= '0;
        end else begin
            if (aw_fire) begin
                aw_wr <= (aw_wr == W_LAST) ? '0 : aw_wr + WPW'(1);
            end
            if (w_last_fire) begin
                aw_rd <= (aw_rd == W_LAST) ? '0 : aw_rd + WPW'(1);
            end
            if (ar_fire) begin
                ar_wr <= (ar_wr == R_LAST) ? '0 : ar_wr + RPW'(1);
            end
            if (r_last_fire) begin
                ar_rd <= (ar_rd == R_LAST) ? '0 : ar_rd + RPW'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care whenever the pointers say empty.
    always_ff @(posedge clk) begin
        if (aw_fire) begin
            aw_mem[aw_wr] <= axi_awlen;
        end
        if (ar_fire) begin
            ar_mem[ar_wr] <= axi_arlen;
        end
    end

    // Beat counters: count beats of the current burst, clear on its last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= '0;
            rcnt <= '0;
        end else begin
            if (w_fire) begin
                wcnt <= axi_wlast ? '0 : wcnt_inc;
            end
            if (r_ok) begin
                rcnt <= axi_rlast ? '0 : rcnt_inc;
            end
        end
    end

    // Sticky error flags, set the cycle after the offending beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_w_len   <= 1'b0;
            err_r_len   <= 1'b0;
            err_b_unexp <= 1'b0;
            err_r_unexp <= 1'b0;
        end else begin
            err_w_len   <= err_w_len | wcnt[8]
                         | (w_last_fire && ({1'b0, aw_head} != wcnt))
                         | (w_fire && !axi_wlast && wcnt_inc[8]);
            err_r_len   <= err_r_len | rcnt[8]
                         | (r_last_fire && ({1'b0, ar_head} != rcnt))
                         | (r_ok && !axi_rlast && rcnt_inc[8]);
            err_b_unexp <= err_b_unexp | (b_fire && (wdone == '0));
            err_r_unexp <= err_r_unexp | (r_fire && (r_cnt == '0));
        end
    end

    // Registered in-flight status.
    always_comb begin
        r_inflight = r_cnt;
        w_inflight = w_cnt;
    end

endmodule

// File: tb/tb_emulib_rammodel_tracker_ex.sv
// Testbench for emulib_rammodel_tracker_ex: directed scenarios on two instances
// (RW_MODE 0 and 1) followed by randomized traffic against a queue-based model.
module tb_emulib_rammodel_tracker_ex;

    localparam int MAXR = 8;
    localparam int MAXW = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       awvalid, wvalid, wlast, arvalid;
    logic       bvalid, bready, rvalid, rready, rlast;
    logic [7:0] awlen, arlen;

    logic       d0_awready, d0_wready, d0_arready;
    logic       d0_err_w_len, d0_err_r_len, d0_err_b_unexp, d0_err_r_unexp;
    logic [3:0] d0_r_inflight, d0_w_inflight;
    logic       d1_awready, d1_wready, d1_arready;
    logic       d1_err_w_len, d1_err_r_len, d1_err_b_unexp, d1_err_r_unexp;
    logic [3:0] d1_r_inflight, d1_w_inflight;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    emulib_rammodel_tracker_ex #(
        .MAX_R_INFLIGHT(MAXR), .MAX_W_INFLIGHT(MAXW), .RW_MODE(0)
    ) d0 (
        .clk(clk), .rst(rst),
        .axi_awvalid(awvalid), .axi_awready(d0_awready), .axi_awlen(awlen),
        .axi_wvalid(wvalid), .axi_wready(d0_wready), .axi_wlast(wlast),
        .axi_arvalid(arvalid), .axi_arready(d0_arready), .axi_arlen(arlen),
        .axi_bvalid(bvalid), .axi_bready(bready),
        .axi_rvalid(rvalid), .axi_rready(rready), .axi_rlast(rlast),
        .r_inflight(d0_r_inflight), .w_inflight(d0_w_inflight),
        .err_w_len(d0_err_w_len), .err_r_len(d0_err_r_len),
        .err_b_unexp(d0_err_b_unexp), .err_r_unexp(d0_err_r_unexp)
    );

    emulib_rammodel_tracker_ex #(
        .MAX_R_INFLIGHT(MAXR), .MAX_W_INFLIGHT(MAXW), .RW_MODE(1)
    ) d1 (
        .clk(clk), .rst(rst),
        .axi_awvalid(awvalid), .axi_awready(d1_awready), .axi_awlen(awlen),
        .axi_wvalid(wvalid), .axi_wready(d1_wready), .axi_wlast(wlast),
        .axi_arvalid(arvalid), .axi_arready(d1_arready), .axi_arlen(arlen),
        .axi_bvalid(bvalid), .axi_bready(bready),
        .axi_rvalid(rvalid), .axi_rready(rready), .axi_rlast(rlast),
        .r_inflight(d1_r_inflight), .w_inflight(d1_w_inflight),
        .err_w_len(d1_err_w_len), .err_r_len(d1_err_r_len),
        .err_b_unexp(d1_err_b_unexp), .err_r_unexp(d1_err_r_unexp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        awvalid = 0; wvalid = 0; wlast = 0; arvalid = 0;
        bvalid = 0; bready = 0; rvalid = 0; rready = 0; rlast = 0;
        awlen = 0; arlen = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    // Reference model state (RW_MODE 0 instance)
    int q_aw[$];
    int q_ar[$];
    int m_wbeats, m_rbeats, m_wdone;
    bit m_ew, m_er, m_ebu, m_eru;

    initial begin
        bit e_aw, e_w, e_ar, f_aw, f_w, f_ar, f_r, f_b;
        int m_wcnt;

        idle();
        rst = 1;
        step();
        step();
        rst = 0;

        // Reset state
        chk("rst_awready", d0_awready, 1);
        chk("rst_wready", d0_wready, 0);
        chk("rst_arready", d0_arready, 1);
        chk("rst_arready_m1", d1_arready, 1);
        chk("rst_r_inflight", d0_r_inflight, 0);
        chk("rst_w_inflight", d0_w_inflight, 0);
        chk("rst_errs", {d0_err_w_len, d0_err_r_len, d0_err_b_unexp, d0_err_r_unexp}, 0);

        // Write burst len=3, then B; B held off to observe ordering modes
        awvalid = 1; awlen = 3;
        step();
        awvalid = 0;
        chk("w1_wready_after_aw", d0_wready, 1);
        chk("w1_w_inflight", d0_w_inflight, 1);
        chk("w1_arready_m0", d0_arready, 0);
        chk("w1_arready_m1_wpend", d1_arready, 0);
        for (int i = 0; i < 4; i++) begin
            wvalid = 1; wlast = (i == 3);
            step();
        end
        wvalid = 0; wlast = 0;
        chk("w1_wready_done", d0_wready, 0);
        chk("w1_w_inflight_noB", d0_w_inflight, 1);
        chk("w1_arready_m1_after_wlast", d1_arready, 1);
        step();
        step();
        chk("w1_arready_m0_noB", d0_arready, 0);
        bvalid = 1; bready = 1;
        step();
        bvalid = 0; bready = 0;
        chk("w1_w_inflight_afterB", d0_w_inflight, 0);
        chk("w1_arready_m0_afterB", d0_arready, 1);
        chk("w1_err_w_len", d0_err_w_len, 0);
        chk("w1_err_b_unexp", d0_err_b_unexp, 0);

        // Fill the read side to MAX_R_INFLIGHT
        arvalid = 1; arlen = 0;
        for (int i = 0; i < MAXR; i++) step();
        chk("r8_r_inflight", d0_r_inflight, MAXR);
        chk("r8_arready_full", d0_arready, 0);
        step();
        chk("r8_no_extra_ar", d0_r_inflight, MAXR);
        arvalid = 0;
        rvalid = 1; rready = 1; rlast = 1;
        step();
        rvalid = 0;
        chk("r8_r_inflight_7", d0_r_inflight, MAXR - 1);
        chk("r8_arready_again", d0_arready, 1);
        rvalid = 1;
        for (int i = 0; i < MAXR - 1; i++) step();
        rvalid = 0; rlast = 0;
        chk("r8_drained", d0_r_inflight, 0);
        chk("r8_err_r_len", d0_err_r_len, 0);

        // AR len=1 with RLAST on the first beat
        arvalid = 1; arlen = 1;
        step();
        arvalid = 0;
        rvalid = 1; rready = 1; rlast = 1;
        step();
        rvalid = 0; rlast = 0;
        chk("rlen_err_set", d0_err_r_len, 1);
        step();
        chk("rlen_err_sticky", d0_err_r_len, 1);
        do_reset();
        chk("rlen_err_cleared", d0_err_r_len, 0);

        // Unexpected R and B
        rvalid = 1; rready = 1;
        step();
        rvalid = 0; rready = 0;
        chk("r_unexp_set", d0_err_r_unexp, 1);
        chk("r_unexp_r_inflight", d0_r_inflight, 0);
        bvalid = 1; bready = 1;
        step();
        bvalid = 0; bready = 0;
        chk("b_unexp_set", d0_err_b_unexp, 1);
        chk("b_unexp_w_inflight", d0_w_inflight, 0);
        do_reset();

        // WLAST on beat 2 of a single-beat burst
        awvalid = 1; awlen = 0;
        step();
        awvalid = 0;
        wvalid = 1; wlast = 0;
        step();
        wlast = 1;
        step();
        wvalid = 0; wlast = 0;
        chk("wlen_err_set", d0_err_w_len, 1);
        chk("wlen_w_inflight", d0_w_inflight, 1);
        do_reset();

        // Write side full
        awvalid = 1; awlen = 0;
        for (int i = 0; i < MAXW; i++) step();
        chk("wfull_awready", d0_awready, 0);
        step();
        awvalid = 0;
        chk("wfull_w_inflight", d0_w_inflight, MAXW);
        do_reset();

        // AW and B in the same cycle with two writes in flight
        for (int i = 0; i < 2; i++) begin
            awvalid = 1; awlen = 0;
            step();
            awvalid = 0; wvalid = 1; wlast = 1;
            step();
            wvalid = 0; wlast = 0;
        end
        chk("awb_pre", d0_w_inflight, 2);
        awvalid = 1; awlen = 2; bvalid = 1; bready = 1;
        step();
        awvalid = 0; bvalid = 0; bready = 0;
        chk("awb_same_cycle", d0_w_inflight, 2);
        chk("awb_no_b_err", d0_err_b_unexp, 0);

        // Reset in the middle of the len=2 burst
        wvalid = 1; wlast = 0;
        step();
        wvalid = 0;
        chk("midburst_wready_pre", d0_wready, 1);
        rst = 1;
        step();
        chk("midburst_wready", d0_wready, 0);
        chk("midburst_w_inflight", d0_w_inflight, 0);
        rst = 0;
        step();

        // Randomized traffic against the reference model
        do_reset();
        q_aw.delete(); q_ar.delete();
        m_wbeats = 0; m_rbeats = 0; m_wdone = 0;
        m_ew = 0; m_er = 0; m_ebu = 0; m_eru = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            m_wcnt = q_aw.size() + m_wdone;
            e_aw = (m_wcnt < MAXW);
            e_w  = (q_aw.size() > 0);
            e_ar = (q_ar.size() < MAXR) && (m_wcnt == 0);
            chk("rnd_awready", d0_awready, e_aw);
            chk("rnd_wready", d0_wready, e_w);
            chk("rnd_arready", d0_arready, e_ar);
            chk("rnd_r_inflight", d0_r_inflight, q_ar.size());
            chk("rnd_w_inflight", d0_w_inflight, m_wcnt);
            chk("rnd_err_w_len", d0_err_w_len, m_ew);
            chk("rnd_err_r_len", d0_err_r_len, m_er);
            chk("rnd_err_b_unexp", d0_err_b_unexp, m_ebu);
            chk("rnd_err_r_unexp", d0_err_r_unexp, m_eru);

            rst     = ($urandom_range(0, 149) == 0);
            awvalid = ($urandom_range(0, 2) == 0);
            awlen   = 8'($urandom_range(0, 3));
            wvalid  = $urandom_range(0, 1) == 1;
            if (q_aw.size() > 0) begin
                wlast = (m_wbeats == q_aw[0]);
                if ($urandom_range(0, 29) == 0) wlast = ~wlast;
            end else begin
                wlast = $urandom_range(0, 1) == 1;
            end
            arvalid = ($urandom_range(0, 2) == 0);
            arlen   = 8'($urandom_range(0, 3));
            rready  = ($urandom_range(0, 3) != 0);
            if (q_ar.size() > 0) begin
                rvalid = $urandom_range(0, 1) == 1;
                rlast  = (m_rbeats == q_ar[0]);
                if ($urandom_range(0, 29) == 0) rlast = ~rlast;
            end else begin
                rvalid = ($urandom_range(0, 59) == 0);
                rlast  = $urandom_range(0, 1) == 1;
            end
            bready = ($urandom_range(0, 3) != 0);
            bvalid = (m_wdone > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 79) == 0);

            f_aw = awvalid && e_aw;
            f_w  = wvalid && e_w;
            f_ar = arvalid && e_ar;
            f_r  = rvalid && rready;
            f_b  = bvalid && bready;
            step();

            if (rst) begin
                q_aw.delete(); q_ar.delete();
                m_wbeats = 0; m_rbeats = 0; m_wdone = 0;
                m_ew = 0; m_er = 0; m_ebu = 0; m_eru = 0;
            end else begin
                // B is judged against completions from earlier cycles only
                if (f_b) begin
                    if (m_wdone == 0) m_ebu = 1;
                    else m_wdone--;
                end
                if (f_w) begin
                    if (wlast) begin
                        if (m_wbeats != q_aw[0]) m_ew = 1;
                        void'(q_aw.pop_front());
                        m_wbeats = 0;
                        m_wdone++;
                    end else begin
                        m_wbeats++;
                        if (m_wbeats >= 256) m_ew = 1;
                    end
                end
                if (f_r) begin
                    if (q_ar.size() == 0) begin
                        m_eru = 1;
                    end else if (rlast) begin
                        if (m_rbeats != q_ar[0]) m_er = 1;
                        void'(q_ar.pop_front());
                        m_rbeats = 0;
                    end else begin
                        m_rbeats++;
                        if (m_rbeats >= 256) m_er = 1;
                    end
                end
                if (f_aw) q_aw.push_back(int'(awlen));
                if (f_ar) q_ar.push_back(int'(arlen));
            end
        end
        idle();
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
